// File: rtl/booth_pkg.sv
// Shared constants for the radix-4 Booth multiplier: partial-product select codes
// and FSM state encoding.
package booth_pkg;

    localparam logic [2:0] M2A  = 3'd1;
    localparam logic [2:0] MA   = 3'd2;
    localparam logic [2:0] ZERO = 3'd3;
    localparam logic [2:0] PA   = 3'd4;
    localparam logic [2:0] P2A  = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a partial-product select code.
module booth_enc
    import booth_pkg::*;
(
    input  logic [2:0] win,
    output logic [2:0] sel
);

    always_comb begin
        sel = ZERO;
        case (win)
            3'b000, 3'b111: sel = ZERO;
            3'b001, 3'b010: sel = PA;
            3'b011:         sel = P2A;
            3'b100:         sel = M2A;
            3'b101, 3'b110: sel = MA;
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define BOOTH_UNSIGNED_EN to add the unsgn port and one extra digit for unsigned operands.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic             unsgn,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
);

`ifdef BOOTH_UNSIGNED_EN
    // Extra headroom bits let zero-extended operands pass through the signed datapath.
    localparam int unsigned AW = W + 1;
    localparam int unsigned MW = W + 3;
    localparam int unsigned KW = $clog2(W / 2 + 1);
`else
    localparam int unsigned AW = W;
    localparam int unsigned MW = W + 1;
    localparam int unsigned KW = $clog2(W / 2);
`endif

    state_e            state_q, state_d;
    logic [AW-1:0]     mcand_q, mcand_d;
    logic [MW-1:0]     mplr_q, mplr_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic [KW-1:0]     k_q, k_d;
    logic [KW-1:0]     k_last;
    logic [2:0]        sel;
    logic [W+1:0]      a_ext, pp;
    logic [2*W-1:0]    pp_wide;
    logic              ext_a, ext_b;
`ifdef BOOTH_UNSIGNED_EN
    logic              unsgn_q, unsgn_d;
`endif

    booth_enc u_enc (
        .win (mplr_q[2:0]),
        .sel (sel)
    );

    always_comb begin
`ifdef BOOTH_UNSIGNED_EN
        ext_a  = unsgn ? 1'b0 : a[W-1];
        ext_b  = unsgn ? 1'b0 : b[W-1];
        k_last = unsgn_q ? KW'(W / 2) : KW'(W / 2 - 1);
`else
        ext_a  = a[W-1];
        ext_b  = b[W-1];
        k_last = KW'(W / 2 - 1);
`endif
    end

    always_comb begin
        a_ext = {{(W + 2 - AW){mcand_q[AW-1]}}, mcand_q};
        pp    = '0;
        case (sel)
            PA:      pp = a_ext;
            P2A:     pp = a_ext << 1;
            MA:      pp = -a_ext;
            M2A:     pp = -(a_ext << 1);
            default: pp = '0;
        endcase
        pp_wide = {{(W - 2){pp[W+1]}}, pp};
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        k_d     = k_q;
`ifdef BOOTH_UNSIGNED_EN
        unsgn_d = unsgn_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
`ifdef BOOTH_UNSIGNED_EN
                    mcand_d = {ext_a, a};
                    mplr_d  = {ext_b, ext_b, b, 1'b0};
                    unsgn_d = unsgn;
`else
                    mcand_d = a;
                    mplr_d  = {b, 1'b0};
`endif
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d  = acc_q + (pp_wide << {k_q, 1'b0});
                mplr_d = {{2{mplr_q[MW-1]}}, mplr_q[MW-1:2]};
                k_d    = k_q + 1'b1;
                if (k_q == k_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
`ifdef BOOTH_UNSIGNED_EN
            unsgn_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
`ifdef BOOTH_UNSIGNED_EN
            unsgn_q <= unsgn_d;
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        p         = acc_q;
    end

    // ext_a is only consumed in the unsigned build's load path.
    logic unused_ext;
    assign unused_ext = ext_a ^ ext_b;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed self-checking bench for booth_mul_seq (W=8) with hand-computed products.
module tb_booth_mul_seq;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           unsgn = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] p;
    logic           busy;

    int errors = 0;
    int checks = 0;

    booth_mul_seq #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef BOOTH_UNSIGNED_EN
        .unsgn     (unsgn),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts edges from acceptance until out_valid, bounded at 20.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic us, input logic [2*W-1:0] exp_p, input int exp_lat);
        int lat;
        check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
        a        = av;
        b        = bv;
        unsgn    = us;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        unsgn    = 1'b0;
        wait_result(lat);
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " p"}, 64'(p), 64'(exp_p));
        check_eq({tag, " in_ready in DONE"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " out_valid after handoff"}, 64'(out_valid), 64'd0);
        check_eq({tag, " busy after handoff"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset in_ready", 64'(in_ready), 64'd1);
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset p", 64'(p), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("7x3", 8'd7, 8'd3, 1'b0, 16'h0015, 4);
        run_op("-128x-128", 8'h80, 8'h80, 1'b0, 16'h4000, 4);
        run_op("-1x5", 8'hFF, 8'd5, 1'b0, 16'hFFFB, 4);
        run_op("55x55", 8'h55, 8'h55, 1'b0, 16'h1C39, 4);
        run_op("FFxFF signed", 8'hFF, 8'hFF, 1'b0, 16'h0001, 4);
`ifdef BOOTH_UNSIGNED_EN
        run_op("FFxFF unsigned", 8'hFF, 8'hFF, 1'b1, 16'hFE01, 5);
        run_op("80x03 unsigned", 8'h80, 8'h03, 1'b1, 16'h0180, 5);
`endif

        // Backpressure: 12 * -3 = -36, with a pending pair that must wait for the handoff.
        a        = 8'd12;
        b        = 8'hFD;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check_eq("bp latency", 64'(lat), 64'd4);
        check_eq("bp p", 64'(p), 64'hFFDC);
        a        = 8'd2;
        b        = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp hold p", 64'(p), 64'hFFDC);
            check_eq("bp hold out_valid", 64'(out_valid), 64'd1);
            check_eq("bp hold in_ready", 64'(in_ready), 64'd0);
            check_eq("bp hold busy", 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp handoff in_ready", 64'(in_ready), 64'd1);
        check_eq("bp handoff busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        check_eq("bp next accepted", 64'(busy), 64'd1);
        wait_result(lat);
        check_eq("bp next latency", 64'(lat), 64'd4);
        check_eq("bp next p", 64'(p), 64'h0006);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during the second CALC cycle aborts the operation.
        a        = 8'd7;
        b        = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        check_eq("abort out_valid", 64'(out_valid), 64'd0);
        check_eq("abort in_ready", 64'(in_ready), 64'd1);
        check_eq("abort busy", 64'(busy), 64'd0);
        check_eq("abort p", 64'(p), 64'd0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq("abort quiet out_valid", 64'(out_valid), 64'd0);
        end
        run_op("7x3 after reset", 8'd7, 8'd3, 1'b0, 16'h0015, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
